// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory stage: access-type encoding and default depth.
package data_mem_pkg;

  localparam int DM_ADDR_WIDTH = 12;

  localparam logic [2:0] MEM_W  = 3'b000;
  localparam logic [2:0] MEM_HS = 3'b001;
  localparam logic [2:0] MEM_HU = 3'b010;
  localparam logic [2:0] MEM_BS = 3'b011;
  localparam logic [2:0] MEM_BU = 3'b100;

endpackage

// File: rtl/data_mem_lane.sv
// Lane logic for one 32-bit word: store merging, load extraction/extension and
// alignment / op-code checking. Purely combinational.
module mem_lane
  import data_mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  mem_op,
  output logic [31:0] merged,
  output logic [31:0] load_data,
  output logic        align_err
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [4:0]  byte_shift;

  assign byte_shift = {lane, 3'b000};
  assign half_sel   = lane[1] ? old_word[31:16] : old_word[15:0];
  assign byte_sel   = old_word[byte_shift +: 8];

  always_comb begin
    merged    = old_word;
    load_data = '0;
    align_err = 1'b0;
    case (mem_op)
      MEM_W: begin
        align_err = (lane != 2'b00);
        merged    = wdata;
        load_data = old_word;
      end
      MEM_HS, MEM_HU: begin
        align_err = lane[0];
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
        load_data = {{16{(mem_op == MEM_HS) & half_sel[15]}}, half_sel};
      end
      MEM_BS, MEM_BU: begin
        merged[byte_shift +: 8] = wdata[7:0];
        load_data = {{24{(mem_op == MEM_BS) & byte_sel[7]}}, byte_sel};
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised data RAM with combinational read, byte/half/word stores,
// range checking and a registered one-cycle write trace.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  range_err;
  logic                  lane_err;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic [31:0]           load_data;
  logic                  commit;

  assign idx       = addr[ADDR_WIDTH+1:2];
  // Addresses past the top of the array are errors, never aliased onto low words.
  assign range_err = |addr[31:ADDR_WIDTH+2];
  assign old_word  = mem[idx];

  mem_lane u_lane (
    .old_word  (old_word),
    .wdata     (wdata),
    .lane      (addr[1:0]),
    .mem_op    (mem_op),
    .merged    (merged),
    .load_data (load_data),
    .align_err (lane_err)
  );

  assign addr_err = range_err | lane_err;
  assign rdata    = (reset || addr_err) ? '0 : load_data;
  assign commit   = mem_write & ~addr_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      if (commit) mem[idx] <= merged;
      wr_valid <= commit;
      if (commit) begin
        wr_addr <= {addr[31:2], 2'b00};
        wr_data <= merged;
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed vector table, async reset sequence,
// then randomized accesses checked against a byte-array reference model.
module tb_data_mem;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [2:0]  mem_op;
  logic [31:0] rdata;
  logic        addr_err;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  data_mem dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .mem_op    (mem_op),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: flat little-endian byte memory of 16 KiB plus expected trace.
  logic [7:0]  rm [16384];
  logic        e_wv;
  logic [31:0] e_wa;
  logic [31:0] e_wd;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16384; i++) rm[i] = 8'h00;
    e_wv = 1'b0;
    e_wa = '0;
    e_wd = '0;
  endtask

  function automatic logic m_err(input logic [2:0] op, input logic [31:0] a);
    if (op > 3'd4) return 1'b1;
    if (a >= 32'h0000_4000) return 1'b1;
    if (op == 3'd0 && (a % 4) != 0) return 1'b1;
    if ((op == 3'd1 || op == 3'd2) && (a % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {rm[b+3], rm[b+2], rm[b+1], rm[b]};
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] op, input logic [31:0] a);
    int b;
    logic [31:0] v;
    if (m_err(op, a)) return 32'h0;
    b = int'(a);
    case (op)
      3'd0: v = m_word(a);
      3'd1, 3'd2: begin
        v = 32'(rm[b+1]) * 256 + 32'(rm[b]);
        if (op == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: begin
        v = 32'(rm[b]);
        if (op == 3'd3 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
    endcase
    return v;
  endfunction

  task automatic m_write(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int n;
    int b;
    logic [31:0] t;
    n = (op == 3'd0) ? 4 : (op <= 3'd2) ? 2 : 1;
    b = int'(a);
    t = d;
    for (int k = 0; k < n; k++) begin
      rm[b+k] = t[7:0];
      t = t >> 8;
    end
  endtask

  // One clock of stimulus: combinational checks before the edge, trace checks after.
  task automatic step(input logic we, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] d, input string nm, input logic use_tab,
                      input logic [31:0] t_rd, input logic t_err);
    logic commit;
    logic [31:0] m_rd;
    logic        m_e;
    mem_write = we;
    mem_op    = op;
    addr      = a;
    wdata     = d;
    #1;
    m_e  = m_err(op, a);
    m_rd = m_read(op, a);
    if (use_tab) begin
      chk({nm, ".rdata"}, rdata, t_rd);
      chk({nm, ".addr_err"}, 32'(addr_err), 32'(t_err));
    end else begin
      chk({nm, ".rdata"}, rdata, m_rd);
      chk({nm, ".addr_err"}, 32'(addr_err), 32'(m_e));
    end
    commit = we && !m_e;
    if (commit) begin
      m_write(op, a, d);
      e_wa = {a[31:2], 2'b00};
      e_wd = m_word(a);
    end
    e_wv = commit;
    @(posedge clk);
    #1;
    chk({nm, ".wr_valid"}, 32'(wr_valid), 32'(e_wv));
    chk({nm, ".wr_addr"}, wr_addr, e_wa);
    chk({nm, ".wr_data"}, wr_data, e_wd);
    $display("step %s we=%0d op=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d wv=%0d",
             nm, we, op, a, d, rdata, addr_err, wr_valid);
    @(negedge clk);
  endtask

  initial begin
    // {we, op, addr, wdata, expected rdata before the edge, expected addr_err}
    vt[0]  = '{1'b1, 3'd0, 32'h0000_0008, 32'h8765_4321, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b0, 3'd0, 32'h0000_0008, 32'h0,         32'h8765_4321, 1'b0};
    vt[2]  = '{1'b1, 3'd3, 32'h0000_0009, 32'h0000_00AA, 32'h0000_0043, 1'b0};
    vt[3]  = '{1'b0, 3'd0, 32'h0000_0008, 32'h0,         32'h8765_AA21, 1'b0};
    vt[4]  = '{1'b1, 3'd1, 32'h0000_000A, 32'h0000_BEEF, 32'hFFFF_8765, 1'b0};
    vt[5]  = '{1'b0, 3'd0, 32'h0000_0008, 32'h0,         32'hBEEF_AA21, 1'b0};
    vt[6]  = '{1'b0, 3'd3, 32'h0000_0009, 32'h0,         32'hFFFF_FFAA, 1'b0};
    vt[7]  = '{1'b0, 3'd4, 32'h0000_0009, 32'h0,         32'h0000_00AA, 1'b0};
    vt[8]  = '{1'b0, 3'd1, 32'h0000_000A, 32'h0,         32'hFFFF_BEEF, 1'b0};
    vt[9]  = '{1'b0, 3'd2, 32'h0000_000A, 32'h0,         32'h0000_BEEF, 1'b0};
    vt[10] = '{1'b1, 3'd0, 32'h0000_0006, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vt[11] = '{1'b1, 3'd1, 32'h0000_0003, 32'h0000_5555, 32'h0000_0000, 1'b1};
    vt[12] = '{1'b0, 3'd0, 32'h0000_0008, 32'h0,         32'hBEEF_AA21, 1'b0};
    vt[13] = '{1'b0, 3'd0, 32'h0000_4000, 32'h0,         32'h0000_0000, 1'b1};
    vt[14] = '{1'b0, 3'd7, 32'h0000_0008, 32'h0,         32'h0000_0000, 1'b1};
    vt[15] = '{1'b1, 3'd0, 32'h0000_0020, 32'h1111_1111, 32'h0000_0000, 1'b0};
    vt[16] = '{1'b1, 3'd0, 32'h0000_0020, 32'h2222_2222, 32'h1111_1111, 1'b0};
    vt[17] = '{1'b0, 3'd0, 32'h0000_0020, 32'h0,         32'h2222_2222, 1'b0};

    reset     = 1'b1;
    addr      = '0;
    wdata     = '0;
    mem_write = 1'b0;
    mem_op    = 3'd0;
    model_clear();
    #2;
    chk("reset.rdata", rdata, 32'h0);
    chk("reset.wr_valid", 32'(wr_valid), 32'h0);
    chk("reset.wr_addr", wr_addr, 32'h0);
    chk("reset.wr_data", wr_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++)
      step(vt[i].we, vt[i].op, vt[i].a, vt[i].d, $sformatf("vec%0d", i), 1'b1,
           vt[i].exp_rd, vt[i].exp_err);

    // Async reset mid-cycle while a trace pulse is live, then a store held under reset.
    step(1'b1, 3'd0, 32'h0000_0010, 32'hCAFE_F00D, "pre_rst", 1'b0, 32'h0, 1'b0);
    mem_write = 1'b0;
    mem_op    = 3'd0;
    addr      = 32'h0000_0010;
    #1;
    chk("pre_rst.rdata", rdata, 32'hCAFE_F00D);
    reset = 1'b1;
    #1;
    chk("async_rst.rdata", rdata, 32'h0);
    chk("async_rst.wr_valid", 32'(wr_valid), 32'h0);
    chk("async_rst.wr_addr", wr_addr, 32'h0);
    chk("async_rst.wr_data", wr_data, 32'h0);
    mem_write = 1'b1;
    addr      = 32'h0000_0014;
    wdata     = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    chk("rst_store.wr_valid", 32'(wr_valid), 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    mem_write = 1'b0;
    model_clear();
    step(1'b0, 3'd0, 32'h0000_0010, 32'h0, "post_rst10", 1'b1, 32'h0, 1'b0);
    step(1'b0, 3'd0, 32'h0000_0014, 32'h0, "post_rst14", 1'b1, 32'h0, 1'b0);
    step(1'b0, 3'd0, 32'h0000_0008, 32'h0, "post_rst08", 1'b1, 32'h0, 1'b0);

    // Randomized traffic, biased to a small window so loads hit earlier stores.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      logic [2:0]  rop;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)      ra = 32'($urandom_range(0, 63));
      else if (sel < 9) ra = 32'h0000_3FF0 + 32'($urandom_range(0, 31));
      else              ra = $urandom | 32'h0001_0000;
      rop = (sel == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      step(1'($urandom_range(0, 1)), rop, ra, $urandom, $sformatf("rnd%0d", i),
           1'b0, 32'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
